// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receive FSM states; the encoding is visible on the top's debug port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit-cell count at which a bit is judged. The vote window is MID-1..MID+1.
  function automatic int calc_mid(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Synchroniser, per-bit baud counter and 3-sample majority voter.
// The baud counter treats the cycle in which the start edge is seen on the
// synchronised line as count 0. When the counter reaches MID, the voter
// combines three values of the synchronised line:
//   - the previous value (count MID-1);
//   - the current value (count MID);
//   - the value one synchroniser stage earlier, which is the value the
//     synchronised line will hold at count MID+1.
// This is why the decision is ready at count MID itself.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic run_i,       // a frame is in progress (START..STOP)
  input  logic restart_i,   // start edge accepted; this cycle was count 0
  output logic rxs_o,       // synchronised line
  output logic fall_o,      // high->low transition on the synchronised line
  output logic bit_val_o,   // voted bit value, meaningful with bit_tick_o
  output logic bit_tick_o   // one-cycle pulse at each bit mid-point
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = calc_mid(CLKS_PER_BIT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   s_early, s_mid, s_late;

  // Synchroniser chain and one-cycle history of the synchronised line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rxs_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxs_o  = sync_q[SYNC_STAGES-1];
  assign fall_o = rxs_prev_q & ~sync_q[SYNC_STAGES-1];

  // Baud counter next value: restart, hold at zero when idle, wrap per bit.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CW'(1);
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Baud counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Majority of the three samples around the mid-point.
  always_comb begin
    s_early    = rxs_prev_q;
    s_mid      = sync_q[SYNC_STAGES-1];
    s_late     = sync_q[SYNC_STAGES-2];
    bit_val_o  = (s_early & s_mid) | (s_early & s_late) | (s_mid & s_late);
    bit_tick_o = run_i && (cnt_q == CW'(MID));
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive engine: frame FSM, shift register and a one-entry holding
// register. Word, parity and framing status are presented together.
//
// Handshake: rx_valid high means rx_data/parity_err/frame_err hold a word.
// The word is taken on every rising clock edge where rx_valid & rx_ready.
// rx_valid never drops without such a transfer. The held word never changes
// while rx_valid is high, unless a transfer happens on the same edge.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output uart_state_e          dbg_state
);

  uart_state_e          state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 stop_low_q, stop_low_d;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, perr_out_q, ferr_out_q, overrun_q;

  logic rxs, fall, bit_val, bit_tick;
  logic run, restart;
  logic complete, comp_ferr;

  assign run = (state_q == ST_START) || (state_q == ST_DATA) ||
               (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sampler (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rx_i       (rx),
    .run_i      (run),
    .restart_i  (restart),
    .rxs_o      (rxs),
    .fall_o     (fall),
    .bit_val_o  (bit_val),
    .bit_tick_o (bit_tick)
  );

  // Frame FSM: next state, data shifting, parity/stop evaluation.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    stop_low_d = stop_low_q;
    restart    = 1'b0;
    complete   = 1'b0;
    comp_ferr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d    = ST_START;
          restart    = 1'b1;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          stop_low_d = 1'b0;
        end
      end
      ST_START: begin
        // A start bit that reads high at its centre was noise.
        if (bit_tick) begin
          state_d = bit_val ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          perr_d  = bit_val ^ (^shift_q) ^ (PARITY == PAR_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!bit_val) begin
            stop_low_d = 1'b1;
          end
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            // Finish at the centre of the last stop bit. A start bit that
            // arrives early is then still caught.
            complete  = 1'b1;
            comp_ferr = stop_low_q | ~bit_val;
            bit_cnt_d = '0;
            state_d   = rxs ? ST_IDLE : ST_BREAK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        // Ignore the line until it returns high, so a long low is one event.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      stop_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      stop_low_q <= stop_low_d;
    end
  end

  // Holding register: load on completion if free or being emptied, else drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (complete) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          perr_out_q <= perr_q;
          ferr_out_q <= comp_ferr;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and a 7E1 instance at 16 clocks/bit.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        rx8, rx_ready8, rx_valid8, parity_err8, frame_err8, overrun8, busy8;
  logic [7:0]  rx_data8;
  uart_state_e dbg_state8;

  logic        rx7, rx_ready7, rx_valid7, parity_err7, frame_err7, overrun7, busy7;
  logic [6:0]  rx_data7;
  uart_state_e dbg_state7;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .SYNC_STAGES (2)
  ) dut8 (
    .clk (clk), .rst (rst), .rx (rx8), .rx_data (rx_data8), .rx_valid (rx_valid8),
    .rx_ready (rx_ready8), .parity_err (parity_err8), .frame_err (frame_err8),
    .overrun (overrun8), .busy (busy8), .dbg_state (dbg_state8)
  );

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY (2), .STOP_BITS (1), .SYNC_STAGES (2)
  ) dut7 (
    .clk (clk), .rst (rst), .rx (rx7), .rx_data (rx_data7), .rx_valid (rx_valid7),
    .rx_ready (rx_ready7), .parity_err (parity_err7), .frame_err (frame_err7),
    .overrun (overrun7), .busy (busy7), .dbg_state (dbg_state7)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entries are {frame_err, parity_err, data}.
  logic [9:0] exp_q8[$];
  logic [8:0] exp_q7[$];
  logic [9:0] e8;
  logic [8:0] e7;
  int rcv8 = 0;
  int rcv7 = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b1 && rx_valid8 && rx_ready8) begin
      rcv8++;
      check("word8_expected", 32'(exp_q8.size() > 0), 32'd1);
      if (exp_q8.size() > 0) begin
        e8 = exp_q8.pop_front();
        check("data8", 32'(rx_data8), 32'(e8[7:0]));
        check("perr8", 32'(parity_err8), 32'(e8[8]));
        check("ferr8", 32'(frame_err8), 32'(e8[9]));
      end
    end
    if (overrun8) ovr_cnt++;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && rx_valid7 && rx_ready7) begin
      rcv7++;
      check("word7_expected", 32'(exp_q7.size() > 0), 32'd1);
      if (exp_q7.size() > 0) begin
        e7 = exp_q7.pop_front();
        check("data7", 32'(rx_data7), 32'(e7[6:0]));
        check("perr7", 32'(parity_err7), 32'(e7[7]));
        check("ferr7", 32'(frame_err7), 32'(e7[8]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One bit cell, starting at a negedge; cycle g of the cell is inverted.
  task automatic drive_bit(input int which, input logic b, input int g);
    for (int j = 0; j < CPB; j++) begin
      if (which == 0) rx8 = (j == g) ? ~b : b;
      else            rx7 = (j == g) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                            input int par, input bit flip_par, input bit stop_low,
                            input int glitch_bit);
    logic p;
    p = 1'b0;
    drive_bit(which, 1'b0, -1);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(which, d[i], (i == glitch_bit) ? 7 : -1);
      p = p ^ d[i];
    end
    if (par != 0) drive_bit(which, p ^ (par == 1) ^ flip_par, -1);
    drive_bit(which, ~stop_low, -1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int b2b[9] = '{11, 13, 15, 17, 19, 111, 113, 115, 117};
  int busy_at, valid_at, rcv_before, ovr_before;

  initial begin
    rst = 1'b0; rx8 = 1'b1; rx7 = 1'b1; rx_ready8 = 1'b1; rx_ready7 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid8), 32'd0);
    check("rst_data", 32'(rx_data8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_ovr", 32'(overrun8), 32'd0);
    check("rst_perr", 32'(parity_err8), 32'd0);
    check("rst_ferr", 32'(frame_err8), 32'd0);
    check("rst_state", 32'(dbg_state8), 32'(ST_IDLE));
    check("rst_busy7", 32'(busy7), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back 8N1 with latency measurement of the first frame.
    busy_at = 0; valid_at = 0;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          exp_q8.push_back({1'b0, 1'b0, 8'(b2b[i])});
          send_frame(0, 9'(b2b[i]), 8, 0, 1'b0, 1'b0, -1);
        end
      end
      begin
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk); #1;
          if (busy8 && busy_at == 0) busy_at = n;
          if (rx_valid8) begin
            valid_at = n;
            break;
          end
        end
      end
    join
    check("lat_busy", 32'(busy_at), 32'd3);
    check("lat_valid", 32'(valid_at), 32'd154);
    repeat (20) @(negedge clk);
    check("b2b_count", 32'(rcv8), 32'd9);
    check("b2b_drain", 32'(exp_q8.size()), 32'd0);

    // 7E1: correct parity, then flipped parity.
    exp_q7.push_back({1'b0, 1'b0, 7'h55});
    send_frame(1, 9'h55, 7, 2, 1'b0, 1'b0, -1);
    exp_q7.push_back({1'b0, 1'b1, 7'h55});
    send_frame(1, 9'h55, 7, 2, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("par_count", 32'(rcv7), 32'd2);
    check("par_drain", 32'(exp_q7.size()), 32'd0);

    // 4-cycle low pulse is a false start.
    rcv_before = rcv8;
    rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    @(negedge clk);
    check("fs_busy", 32'(busy8), 32'd1);
    repeat (3 * CPB) @(negedge clk);
    check("fs_state", 32'(dbg_state8), 32'(ST_IDLE));
    check("fs_nowords", 32'(rcv8), 32'(rcv_before));

    // Single-cycle glitch at the centre of data bit 3.
    exp_q8.push_back({1'b0, 1'b0, 8'hA5});
    send_frame(0, 9'hA5, 8, 0, 1'b0, 1'b0, 3);
    repeat (20) @(negedge clk);
    check("glitch_drain", 32'(exp_q8.size()), 32'd0);

    // Low stop bit, then line held low: framing error and BREAK.
    exp_q8.push_back({1'b1, 1'b0, 8'h3C});
    send_frame(0, 9'h3C, 8, 0, 1'b0, 1'b1, -1);
    rx8 = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    check("brk_state", 32'(dbg_state8), 32'(ST_BREAK));
    check("brk_busy", 32'(busy8), 32'd1);
    check("brk_drain", 32'(exp_q8.size()), 32'd0);
    rx8 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("brk_exit", 32'(dbg_state8), 32'(ST_IDLE));
    exp_q8.push_back({1'b0, 1'b0, 8'h42});
    send_frame(0, 9'h42, 8, 0, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("after_brk_drain", 32'(exp_q8.size()), 32'd0);

    // Overrun: holding register full when the second word completes.
    @(posedge clk); #1 rx_ready8 = 1'b0;
    @(negedge clk);
    ovr_before = ovr_cnt;
    exp_q8.push_back({1'b0, 1'b0, 8'h01});
    send_frame(0, 9'h01, 8, 0, 1'b0, 1'b0, -1);
    send_frame(0, 9'h02, 8, 0, 1'b0, 1'b0, -1);
    repeat (2 * CPB) @(negedge clk);
    check("ovr_valid", 32'(rx_valid8), 32'd1);
    check("ovr_held", 32'(rx_data8), 32'h01);
    check("ovr_pulses", 32'(ovr_cnt - ovr_before), 32'd1);
    @(posedge clk); #1 rx_ready8 = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_drop", 32'(rx_valid8), 32'd0);
    check("ovr_drain", 32'(exp_q8.size()), 32'd0);

    // Reset during data bit 4: frame abandoned, nothing delivered.
    rcv_before = rcv8;
    fork
      send_frame(0, 9'h77, 8, 0, 1'b0, 1'b0, -1);
      begin
        repeat (5 * CPB + 8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(rx_valid8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_state", 32'(dbg_state8), 32'(ST_IDLE));
        check("mid_rst_data", 32'(rx_data8), 32'd0);
        check("mid_rst_ovr", 32'(overrun8), 32'd0);
      end
    join
    check("mid_rst_nowords", 32'(rcv8), 32'(rcv_before));
    rst = 1'b1;
    repeat (20) @(negedge clk);
    exp_q8.push_back({1'b0, 1'b0, 8'h9E});
    send_frame(0, 9'h9E, 8, 0, 1'b0, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("post_rst_count", 32'(rcv8), 32'(rcv_before + 1));
    check("final_drain8", 32'(exp_q8.size()), 32'd0);
    check("final_drain7", 32'(exp_q7.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
